// File: rtl/hazard_scoreboard.sv
// Load-use hazard detector and EX/MEM/WB destination-tag pipeline for a 5-stage MIPS core.
// Optional HAZARD_STATS_EN adds a saturating 16-bit load-use stall counter on stall_cnt_o.
module hazard_scoreboard (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_rt_used_i,
  input  logic [4:0] id_rd_i,
  input  logic       id_regwrite_i,
  input  logic       id_memread_i,
  input  logic       flush_i,
  output logic       stall_o,
  output logic [4:0] id_ex_rs_o,
  output logic [4:0] id_ex_rt_o,
  output logic [4:0] ex_mem_rd_o,
  output logic       ex_mem_regwrite_o,
  output logic [4:0] mem_wb_rd_o,
  output logic       mem_wb_regwrite_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } ex_stage_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } mem_stage_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
  } wb_stage_t;

  ex_stage_t  ex_q,  ex_d;
  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q,  wb_d;

  logic id_live;
  logic load_use;

  // A load in EX whose result the ID instruction needs cannot be forwarded in time.
  always_comb begin
    id_live  = id_valid_i & ~flush_i;
    load_use = ex_q.memread && (ex_q.rd != 5'd0) &&
               ((ex_q.rd == id_rs_i) || (id_rt_used_i && (ex_q.rd == id_rt_i)));
    stall_o  = id_live & load_use;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ex_d = '0;
    if (id_live && !stall_o) begin
      ex_d.rs       = id_rs_i;
      ex_d.rt       = id_rt_i;
      ex_d.rd       = id_rd_i;
      ex_d.regwrite = id_regwrite_i;
      ex_d.memread  = id_memread_i;
    end
    mem_d.rd       = ex_q.rd;
    mem_d.regwrite = ex_q.regwrite;
    mem_d.memread  = ex_q.memread;
    wb_d.rd        = mem_q.rd;
    wb_d.regwrite  = mem_q.regwrite;
  end

  // NOTE: state registers use non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // MEM memread is carried for a future MEM-stage check; nothing consumes it today.
  logic unused_mem_memread;
  assign unused_mem_memread = mem_q.memread;

  assign id_ex_rs_o        = ex_q.rs;
  assign id_ex_rt_o        = ex_q.rt;
  assign ex_mem_rd_o       = mem_q.rd;
  assign ex_mem_regwrite_o = mem_q.regwrite;
  assign mem_wb_rd_o       = wb_q.rd;
  assign mem_wb_regwrite_o = wb_q.regwrite;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them. Define HAZARD_STATS_EN to also check the counter.
module tb_hazard_scoreboard;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       id_valid_i;
  logic [4:0] id_rs_i, id_rt_i, id_rd_i;
  logic       id_rt_used_i, id_regwrite_i, id_memread_i, flush_i;
  logic       stall_o;
  logic [4:0] id_ex_rs_o, id_ex_rt_o, ex_mem_rd_o, mem_wb_rd_o;
  logic       ex_mem_regwrite_o, mem_wb_regwrite_o;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_o;
`endif

  hazard_scoreboard dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_valid_i        (id_valid_i),
    .id_rs_i           (id_rs_i),
    .id_rt_i           (id_rt_i),
    .id_rt_used_i      (id_rt_used_i),
    .id_rd_i           (id_rd_i),
    .id_regwrite_i     (id_regwrite_i),
    .id_memread_i      (id_memread_i),
    .flush_i           (flush_i),
    .stall_o           (stall_o),
    .id_ex_rs_o        (id_ex_rs_o),
    .id_ex_rt_o        (id_ex_rt_o),
    .ex_mem_rd_o       (ex_mem_rd_o),
    .ex_mem_regwrite_o (ex_mem_regwrite_o),
    .mem_wb_rd_o       (mem_wb_rd_o),
    .mem_wb_regwrite_o (mem_wb_regwrite_o)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt_o       (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic        stall;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  mem_rd;
    logic        mem_rw;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt  = 16'd0;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, req);
    end
  endtask

  // Drive one ID cycle, queue the outputs expected while it is presented, then advance one edge.
  task automatic cyc(input int c, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic used, input logic [4:0] rd, input logic rw, input logic mr,
                     input logic fl, input logic es, input logic [4:0] ers, input logic [4:0] ert,
                     input logic [4:0] emrd, input logic emrw, input logic [4:0] ewrd,
                     input logic ewrw);
    exp_t e;
    id_valid_i    = v;
    id_rs_i       = rs;
    id_rt_i       = rt;
    id_rt_used_i  = used;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    flush_i       = fl;
    e.cyc = c; e.stall = es; e.ex_rs = ers; e.ex_rt = ert;
    e.mem_rd = emrd; e.mem_rw = emrw; e.wb_rd = ewrd; e.wb_rw = ewrw; e.cnt = exp_cnt;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (es && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic idle(input int c, input logic [4:0] ers, input logic [4:0] ert,
                      input logic [4:0] emrd, input logic emrw, input logic [4:0] ewrd,
                      input logic ewrw);
    cyc(c, 0, 0, 0, 0, 0, 0, 0, 0, 0, ers, ert, emrd, emrw, ewrd, ewrw);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall_o",           e.cyc, 32'(stall_o),           32'(e.stall));
        check("id_ex_rs_o",        e.cyc, 32'(id_ex_rs_o),        32'(e.ex_rs));
        check("id_ex_rt_o",        e.cyc, 32'(id_ex_rt_o),        32'(e.ex_rt));
        check("ex_mem_rd_o",       e.cyc, 32'(ex_mem_rd_o),       32'(e.mem_rd));
        check("ex_mem_regwrite_o", e.cyc, 32'(ex_mem_regwrite_o), 32'(e.mem_rw));
        check("mem_wb_rd_o",       e.cyc, 32'(mem_wb_rd_o),       32'(e.wb_rd));
        check("mem_wb_regwrite_o", e.cyc, 32'(mem_wb_regwrite_o), 32'(e.wb_rw));
`ifdef HAZARD_STATS_EN
        check("stall_cnt_o",       e.cyc, 32'(stall_cnt_o),       32'(e.cnt));
`endif
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_i = 1'b0;
    id_valid_i = 0; id_rs_i = 0; id_rt_i = 0; id_rt_used_i = 0;
    id_rd_i = 0; id_regwrite_i = 0; id_memread_i = 0; flush_i = 0;
    @(posedge clk_i);
    #1;
    // Reset held: all outputs zero even with a live ID instruction.
    cyc(0, 1, 3, 3, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;

    // Load-use on rs: lw $8 ; add $9,$8,$1
    cyc(1, 1, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(2, 1, 8, 1, 1, 9, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(3, 1, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 8, 1, 0, 0);
    // rt not used: lw $10 ; addi with rt=10, rt_used=0
    cyc(4, 1, 2, 0, 0, 10, 1, 1, 0, 0, 8, 1, 0, 0, 8, 1);
    cyc(5, 1, 3, 10, 0, 11, 1, 0, 0, 0, 2, 0, 9, 1, 0, 0);
    idle(6, 3, 10, 10, 1, 9, 1);
    // Register 0: lw $0 ; add $9,$0,$0
    cyc(7, 1, 4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 11, 1, 10, 1);
    cyc(8, 1, 0, 0, 1, 9, 1, 0, 0, 0, 4, 0, 0, 0, 11, 1);
    idle(9, 0, 0, 0, 1, 0, 0);
    idle(10, 0, 0, 9, 1, 0, 1);
    // Flush precedence: lw $12 ; dependent user with flush_i=1
    cyc(11, 1, 5, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0, 0, 9, 1);
    cyc(12, 1, 12, 6, 1, 13, 1, 0, 1, 0, 5, 0, 0, 0, 0, 0);
    idle(13, 0, 0, 12, 1, 0, 0);
    idle(14, 0, 0, 0, 0, 12, 1);
    // Propagation: add $5 reaches WB three edges later
    cyc(15, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(16, 1, 2, 0, 0, 0, 0);
    idle(17, 0, 0, 5, 1, 0, 0);
    idle(18, 0, 0, 0, 0, 5, 1);
    // Back-to-back lw $7 ; lw $7 ; add $3,$7,$4 -> stall only on second pair
    cyc(19, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(20, 1, 2, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(21, 1, 7, 4, 1, 3, 1, 0, 0, 1, 2, 0, 7, 1, 0, 0);
    cyc(22, 1, 7, 4, 1, 3, 1, 0, 0, 0, 0, 0, 7, 1, 7, 1);
    idle(23, 7, 4, 0, 0, 7, 1);
    idle(24, 0, 0, 3, 1, 0, 0);
    idle(25, 0, 0, 0, 0, 3, 1);
    // Load-use on rt: lw $14 ; store reading rt=14
    cyc(26, 1, 1, 0, 0, 14, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(27, 1, 2, 14, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(28, 1, 2, 14, 1, 0, 0, 0, 0, 0, 0, 0, 14, 1, 0, 0);
    idle(29, 2, 14, 0, 0, 14, 1);
    // Reset mid-stall: lw $15 ; user of $15, then pull reset before the edge
    cyc(30, 1, 1, 0, 0, 15, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    begin
      exp_t e;
      id_valid_i = 1; id_rs_i = 15; id_rt_i = 0; id_rt_used_i = 0;
      id_rd_i = 16; id_regwrite_i = 1; id_memread_i = 0; flush_i = 0;
      e.cyc = 31; e.stall = 1; e.ex_rs = 1; e.ex_rt = 0;
      e.mem_rd = 0; e.mem_rw = 0; e.wb_rd = 0; e.wb_rw = 0; e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    exp_cnt = 16'd0;
    check("rst_stall_o",    31, 32'(stall_o),           32'd0);
    check("rst_id_ex_rs_o", 31, 32'(id_ex_rs_o),        32'd0);
    check("rst_ex_mem_rd",  31, 32'(ex_mem_rd_o),       32'd0);
    check("rst_ex_mem_rw",  31, 32'(ex_mem_regwrite_o), 32'd0);
    check("rst_mem_wb_rd",  31, 32'(mem_wb_rd_o),       32'd0);
    check("rst_mem_wb_rw",  31, 32'(mem_wb_regwrite_o), 32'd0);
`ifdef HAZARD_STATS_EN
    check("rst_stall_cnt",  31, 32'(stall_cnt_o),       32'd0);
`endif
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    // First edge after release loads the held ID instruction into EX.
    idle(32, 15, 0, 0, 0, 0, 0);
    idle(33, 0, 0, 16, 1, 0, 0);

    repeat (3) @(posedge clk_i);
    check("queue_drained", 99, 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk_i (input, 1, rising-edge clock) and rst_i (input, 1, async active-low reset).
REQ-002 id_valid_i  input  1  ID stage holds a real instruction.
REQ-003 id_rs_i / id_rt_i  input  5 each  ID source register numbers.
REQ-004 id_rt_used_i  input  1  ID instruction reads rt (R-type, store, branch).
REQ-005 id_rd_i  input  5  ID destination register, already muxed from rd or rt.
REQ-006 id_regwrite_i / id_memread_i  input  1 each  ID writes the register file / ID is a load.
REQ-007 flush_i  input  1  squash the ID instruction (taken branch or jump).
REQ-008 stall_o  output  1  load-use stall: PC and IF/ID hold, bubble inserted into EX.
REQ-009 id_ex_rs_o / id_ex_rt_o  output  5 each  EX-stage source tags for the forwarding unit.
REQ-010 ex_mem_rd_o, ex_mem_regwrite_o  output  5, 1  MEM-stage destination tag.
REQ-011 mem_wb_rd_o, mem_wb_regwrite_o  output  5, 1  WB-stage destination tag.
REQ-012 stall_cnt_o  output  16  load-use stall counter; present only with HAZARD_STATS_EN.

Function
REQ-013 The block SHALL hold three tag stages: EX (rs, rt, rd, regwrite, memread), MEM (rd, regwrite, memread) and WB (rd, regwrite).
REQ-014 stall_o SHALL be combinational and equal: id_valid_i & !flush_i & EX.memread & (EX.rd != 0) & ((EX.rd == id_rs_i) | (id_rt_used_i & EX.rd == id_rt_i)).
REQ-015 On each rising edge, MEM SHALL load EX and WB SHALL load MEM, unconditionally.
REQ-016 On each rising edge, EX SHALL load the ID fields when id_valid_i & !flush_i & !stall_o; otherwise EX SHALL load a bubble (all fields 0).
REQ-017 A load-use pair SHALL produce exactly one stall cycle. The next cycle, the load is in MEM with memread=1, EX is a bubble, and stall_o falls.
REQ-018 When flush_i and a hazard occur in the same cycle, flush SHALL win: stall_o=0 and EX gets a bubble.
REQ-019 A destination of register 0 SHALL pass through the stages, but SHALL NOT cause a stall.
REQ-020 The outputs SHALL be registered stage values: id_ex_* from EX, ex_mem_* from MEM, mem_wb_* from WB.
REQ-021 Back-to-back loads to the same rd with a dependent third instruction SHALL stall only on the second load → user pair.

Reset
REQ-022 While rst_i=0, all stages SHALL clear asynchronously to bubbles, so every output is 0 and stall_o=0.
REQ-023 A reset asserted mid-stall SHALL drop stall_o in the same cycle; after release, the first edge loads EX from ID per REQ-016.
REQ-024 stall_cnt_o SHALL reset to 0.

Configuration
REQ-025 With macro HAZARD_STATS_EN defined:
- stall_cnt_o SHALL increment on every rising edge where stall_o=1.
- It SHALL saturate at 16'hFFFF.
REQ-026 Without HAZARD_STATS_EN, the port stall_cnt_o and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Load-use on rs: lw $8 then add $9,$8,$1 → stall_o=1 for one cycle; next cycle ex_mem_rd_o=8 and id_ex_rs_o=0 (bubble).
REQ-028 rt not used: lw $8 then addi $9,$8 with rt=8 and id_rt_used_i=0 → stall_o=0.
REQ-029 Register 0: lw $0 then add $9,$0,$0 → no stall; tags propagate to mem_wb_rd_o=0 two cycles later.
REQ-030 Flush precedence: hazard plus flush_i=1 in the same cycle → stall_o=0; next cycle ex_mem and id_ex fields are all 0.
REQ-031 Propagation: non-load add $5 → three edges later mem_wb_rd_o=5 and mem_wb_regwrite_o=1.
REQ-032 Reset mid-stall, and counter:
- Reset while stall_o=1 → outputs 0 immediately.
- With HAZARD_STATS_EN, three separate load-use pairs → stall_cnt_o=3.
